fetch_prefetch_stage: RTL and testbench

- Instruction fetch stage sitting directly upstream of the single-cycle decode/execute datapath.
- Owns the fetch PC and issues word requests to instruction memory over a single-outstanding req/rvalid handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over valid/ready.
- Accepts branch/jump redirects from the datapath, flushing buffered and in-flight fetches.

---
 rtl/fetch_prefetch_stage.sv | 87 ++++++++
 tb/tb_fetch_prefetch_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_stage.sv
// fetch_prefetch_stage: single-outstanding instruction fetch feeding decode through a PC-tagged FIFO.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_prefetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          AW       = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    state_t        state, state_n;
    logic [31:0]   fetch_pc, req_addr;
    logic          discard;
    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   buf_pc [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          rsp, accept, issue, push, pop, byp;

    assign imem_req  = state == S_WAIT;
    assign imem_addr = req_addr;

    // Issuing only with a free slot means a response can always be pushed.
    always_comb begin
        rsp     = state == S_WAIT && imem_rvalid;
        accept  = rsp && !discard && !redirect;
        issue   = state == S_IDLE && count < FULL && !redirect;
        state_n = issue ? S_WAIT : rsp ? S_IDLE : state;
`ifdef FETCH_BYPASS_EN
        byp     = accept && count == '0;
`else
        byp     = 1'b0;
`endif
        out_valid = count != '0 || byp;
        out_instr = byp ? imem_rdata : buf_instr[rd_ptr];
        out_pc    = byp ? req_addr : buf_pc[rd_ptr];
        out_pc4   = out_pc + 32'd4;
        pop       = count != '0 && out_ready;
        push      = accept && !(byp && out_ready);
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;

    // A redirect while waiting keeps the old request alive and drops its data on arrival.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            discard  <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) req_addr <= fetch_pc;
            fetch_pc <= redirect ? redirect_pc & ~32'h3 : accept ? req_addr + 32'd4 : fetch_pc;
            discard  <= rsp ? 1'b0 : (state == S_WAIT && redirect) ? 1'b1 : discard;
            rd_ptr   <= redirect ? '0 : rd_ptr + AW'(pop);
            wr_ptr   <= redirect ? '0 : wr_ptr + AW'(push);
            count    <= redirect ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= req_addr;
        end
endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// tb_fetch_prefetch_stage: randomized and directed checks of fetch_prefetch_stage against a stream-level model.
module tb_fetch_prefetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0, reset_n = 1'b0, imem_rvalid = 1'b0, redirect = 1'b0, out_ready = 1'b0;
    logic [31:0] imem_rdata = '0, redirect_pc = '0;
    logic imem_req, out_valid;
    logic [31:0] imem_addr, out_instr, out_pc, out_pc4;

    int checks = 0, errors = 0, cyc = 0;
    int lat_cfg = 1, cnt = 0;
    bit lat_rand = 1'b0, inj = 1'b0, busy = 1'b0;
    logic [31:0] starts[$], pops[$];
    int start_cyc[$];
    int first_rv = -1, first_ov = -1, occ = 0;
    bit active = 1'b0, drop = 1'b0;
    logic [31:0] exp_fetch = RESET_PC, exp_out = RESET_PC, hold = '0;

    fetch_prefetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Instruction memory: answers each request after lat cycles with one rvalid pulse.
    always @(negedge clk) begin
        #1;
        if (!reset_n) begin
            imem_rvalid = 1'b0;
            busy = 1'b0;
        end else if (inj) begin
            imem_rvalid = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            inj = 1'b0;
        end else begin
            if (imem_rvalid) begin
                imem_rvalid = 1'b0;
                busy = 1'b0;
            end
            if (imem_req && !busy) begin
                busy = 1'b1;
                cnt = lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                end
            end
        end
    end

    // Stream model: consumed PCs run +4 from the last target, request addresses likewise.
    always @(negedge clk) begin
        bit push, byp, ev;
        #2;
        cyc++;
        if (!reset_n) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
            checks++;
            if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
            occ = 0; active = 0; drop = 0; exp_fetch = RESET_PC; exp_out = RESET_PC;
            first_rv = -1; first_ov = -1;
        end else begin
            if (imem_req && !active) begin
                checks++;
                if (imem_addr !== exp_fetch) begin errors++; $display("FAIL start_addr: got %h want %h", imem_addr, exp_fetch); end
                checks++;
                if (occ >= DEPTH) begin errors++; $display("FAIL start_full: occupancy %0d want <%0d", occ, DEPTH); end
                starts.push_back(imem_addr);
                start_cyc.push_back(cyc);
                exp_fetch = imem_addr + 32'd4;
                hold = imem_addr;
                active = 1'b1;
            end
            checks++;
            if (imem_req !== active) begin errors++; $display("FAIL req_level: got %b want %b", imem_req, active); end
            if (active) begin
                checks++;
                if (imem_addr !== hold) begin errors++; $display("FAIL addr_hold: got %h want %h", imem_addr, hold); end
            end
            push = imem_rvalid && active && !drop && !redirect;
            byp = BYP && push && occ == 0;
            ev = occ > 0 || byp;
            checks++;
            if (out_valid !== ev) begin errors++; $display("FAIL out_valid: got %b want %b", out_valid, ev); end
            if (ev && out_ready) begin
                checks++;
                if (out_pc !== exp_out) begin errors++; $display("FAIL out_pc: got %h want %h", out_pc, exp_out); end
                checks++;
                if (out_instr !== mem_word(exp_out)) begin errors++; $display("FAIL out_instr: got %h want %h", out_instr, mem_word(exp_out)); end
                checks++;
                if (out_pc4 !== exp_out + 32'd4) begin errors++; $display("FAIL out_pc4: got %h want %h", out_pc4, exp_out + 32'd4); end
                pops.push_back(out_pc);
                exp_out = exp_out + 32'd4;
            end
            if (imem_rvalid && active && first_rv < 0) first_rv = cyc;
            if (out_valid && first_ov < 0) first_ov = cyc;
            occ = redirect ? 0 : occ + int'(push) - int'(ev && out_ready);
            if (imem_rvalid && active) begin
                active = 1'b0;
                drop = 1'b0;
            end else if (redirect && active) drop = 1'b1;
            if (redirect) begin
                exp_fetch = redirect_pc & ~32'h3;
                exp_out = redirect_pc & ~32'h3;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        starts.delete(); start_cyc.delete(); pops.delete();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk); #3;
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        checks++; if (out_pc4 !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %h want 4", out_pc4); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", out_instr); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_sequential();
        lat_cfg = 1; out_ready = 1'b1;
        do_reset();
        repeat (20) @(negedge clk);
        #3;
        checks++;
        if (starts.size() < 4 || pops.size() < 4) begin
            errors++; $display("FAIL seq_count: got %0d starts %0d pops want >=4", starts.size(), pops.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (starts[i] !== RESET_PC + 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, starts[i], RESET_PC + 32'(4 * i)); end
                checks++;
                if (pops[i] !== RESET_PC + 32'(4 * i)) begin errors++; $display("FAIL seq_pop%0d: got %h want %h", i, pops[i], RESET_PC + 32'(4 * i)); end
            end
        end
        checks++;
        if (first_ov - first_rv !== (BYP ? 0 : 1)) begin
            errors++; $display("FAIL seq_latency: got %0d want %0d", first_ov - first_rv, BYP ? 0 : 1);
        end
    endtask

    task automatic test_full();
        lat_cfg = 1; out_ready = 1'b0;
        do_reset();
        repeat (40) @(negedge clk);
        #3;
        checks++; if (starts.size() !== DEPTH) begin errors++; $display("FAIL full_reqs: got %0d want %0d", starts.size(), DEPTH); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_idle: got %b want 0", imem_req); end
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        repeat (10) @(negedge clk);
        #3;
        checks++;
        if (pops.size() !== 1 || pops[0] !== RESET_PC) begin errors++; $display("FAIL full_pop: got %0d pops first %h want 1 at %h", pops.size(), pops.size() ? pops[0] : 32'hx, RESET_PC); end
        checks++;
        if (starts.size() !== 5 || starts[4] !== RESET_PC + 32'h10) begin errors++; $display("FAIL full_resume: got %0d starts want 5 ending %h", starts.size(), RESET_PC + 32'h10); end
    endtask

    task automatic test_redirect_wait();
        int s0, n0, stale;
        lat_cfg = 3; out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 60 && starts.size() < 3; k++) begin @(negedge clk); #3; end
        checks++;
        if (starts.size() < 3 || starts[2] !== 32'h8) begin errors++; $display("FAIL rw_setup: got %0d starts want third at 8", starts.size()); end
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        #3;
        s0 = starts.size(); n0 = pops.size();
        @(negedge clk);
        redirect = 1'b0;
        repeat (30) @(negedge clk);
        #3;
        checks++;
        if (starts.size() <= s0 || starts[s0] !== 32'h100) begin errors++; $display("FAIL rw_next_addr: got %0d starts want next at 100", starts.size()); end
        checks++;
        if (pops.size() <= n0 || pops[n0] !== 32'h100) begin errors++; $display("FAIL rw_first_pop: got %0d pops want next pc 100", pops.size()); end
        stale = 0;
        for (int i = n0; i < pops.size(); i++) if (pops[i] < 32'h100) stale++;
        checks++;
        if (stale != 0) begin errors++; $display("FAIL rw_stale: got %0d stale pops want 0", stale); end
    endtask

    task automatic test_redirect_same();
        int s0, n0, rc;
        lat_cfg = 2; out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 60 && starts.size() < 2; k++) begin @(negedge clk); #3; end
        checks++;
        if (starts.size() < 2) begin errors++; $display("FAIL rs_setup: got %0d starts want 2", starts.size()); end
        @(negedge clk);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        #3;
        rc = cyc; s0 = starts.size(); n0 = pops.size();
        checks++;
        if (imem_rvalid !== 1'b1) begin errors++; $display("FAIL rs_coincide: got rvalid %b want 1", imem_rvalid); end
        @(negedge clk);
        redirect = 1'b0;
        repeat (20) @(negedge clk);
        #3;
        checks++;
        if (starts.size() <= s0 || starts[s0] !== 32'h200 || start_cyc[s0] !== rc + 2) begin
            errors++; $display("FAIL rs_next_req: got %0d starts want 200 at cycle %0d", starts.size(), rc + 2);
        end
        checks++;
        if (pops.size() <= n0 || pops[n0] !== 32'h200) begin errors++; $display("FAIL rs_first_pop: got %0d pops want next pc 200", pops.size()); end
    endtask

    task automatic test_wrap();
        int s0;
        bit seen;
        lat_cfg = 1; out_ready = 1'b1;
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        #3;
        s0 = starts.size();
        @(negedge clk);
        redirect = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk); #3;
            if (out_valid && out_pc === 32'hFFFF_FFFC) begin
                seen = 1'b1;
                checks++;
                if (out_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want 00000000", out_pc4); end
            end
        end
        if (!seen) begin checks++; errors++; $display("FAIL wrap_seen: got no FFFFFFFC at out want one"); end
        repeat (10) @(negedge clk);
        #3;
        checks++;
        if (starts.size() < s0 + 3 || starts[s0] !== 32'hFFFF_FFF8 || starts[s0+1] !== 32'hFFFF_FFFC || starts[s0+2] !== 32'h0) begin
            errors++; $display("FAIL wrap_addrs: got %0d starts after redirect want FFFFFFF8,FFFFFFFC,0", starts.size() - s0);
        end
    endtask

    task automatic test_reset_mid();
        lat_cfg = 3; out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 60 && starts.size() < 2; k++) begin @(negedge clk); #3; end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req: got %b want 0", imem_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        @(negedge clk);
        @(negedge clk);
        starts.delete(); start_cyc.delete(); pops.delete();
        reset_n = 1'b1;
        inj = 1'b1;
        repeat (15) @(negedge clk);
        #3;
        checks++;
        if (starts.size() < 1 || starts[0] !== RESET_PC) begin errors++; $display("FAIL mid_restart: got %0d starts want first at %h", starts.size(), RESET_PC); end
        checks++;
        if (pops.size() < 1 || pops[0] !== RESET_PC) begin errors++; $display("FAIL mid_first_pop: got %0d pops want first pc %h", pops.size(), RESET_PC); end
    endtask

    task automatic test_random();
        int n0;
        lat_rand = 1'b1;
        n0 = pops.size();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            out_ready = $urandom_range(0, 3) != 0;
            redirect = $urandom_range(0, 19) == 0;
            redirect_pc = $urandom;
        end
        @(negedge clk);
        redirect = 1'b0;
        lat_rand = 1'b0;
        repeat (5) @(negedge clk);
        #3;
        checks++;
        if (pops.size() - n0 < 100) begin errors++; $display("FAIL rand_progress: got %0d pops want >=100", pops.size() - n0); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full();
        test_redirect_wait();
        test_redirect_same();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
